// File: rtl/demux_1ton_reg.sv
// Registered 1-to-N demultiplexer with valid/ready on the input and on each channel.
// Out-of-range selects are always accepted, discarded and counted in a saturating counter.
module demux_1ton_reg #(
  parameter int DW   = 8,
  parameter int NCH  = 4,
  parameter int SELW = 4,
  parameter int CNTW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DW-1:0]       in_data,
  input  logic [SELW-1:0]     in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [NCH*DW-1:0]   out_data,
  output logic [NCH-1:0]      out_valid,
  input  logic [NCH-1:0]      out_ready,
  output logic [CNTW-1:0]     drop_cnt
);

  // One extra bit so NCH itself is representable when NCH == 2**SELW.
  localparam logic [SELW:0] LP_NCH = (SELW+1)'(NCH);

  logic            w_selOk;
  logic [NCH-1:0]  w_hit;
  logic [NCH-1:0]  w_space;
  logic [NCH-1:0]  w_load;
  logic            w_drop;
  logic [CNTW-1:0] r_dropCnt;

  assign w_selOk  = ({1'b0, in_sel} < LP_NCH);
  assign w_drop   = in_valid & ~w_selOk;
  assign in_ready = ~w_selOk | (|(w_hit & w_space));
  assign drop_cnt = r_dropCnt;

  genvar gi;
  for (gi = 0; gi < NCH; gi++) begin : g_ch
    logic [DW-1:0] r_data;
    logic          r_full;

    // A slot is free if empty or if its consumer takes the word this cycle.
    assign w_hit[gi]   = (in_sel == SELW'(gi));
    assign w_space[gi] = ~r_full | out_ready[gi];
    assign w_load[gi]  = in_valid & w_hit[gi] & w_space[gi];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data <= '0;
        r_full <= 1'b0;
      end else if (w_load[gi]) begin
        r_data <= in_data;
        r_full <= 1'b1;
      end else if (out_ready[gi]) begin
        r_full <= 1'b0;
      end
    end

    assign out_data[gi*DW +: DW] = r_data;
    assign out_valid[gi]         = r_full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dropCnt <= '0;
    end else if (w_drop && !(&r_dropCnt)) begin
      r_dropCnt <= r_dropCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_1ton_reg.sv
// Testbench for demux_1ton_reg: vector table, streaming, drop saturation and async reset.
module tb_demux_1ton_reg;

  localparam int DW   = 8;
  localparam int NCH  = 4;
  localparam int SELW = 4;
  localparam int CNTW = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [DW-1:0]       in_data;
  logic [SELW-1:0]     in_sel;
  logic                in_valid;
  logic                in_ready;
  logic [NCH*DW-1:0]   out_data;
  logic [NCH-1:0]      out_valid;
  logic [NCH-1:0]      out_ready;
  logic [CNTW-1:0]     drop_cnt;

  demux_1ton_reg #(.DW(DW), .NCH(NCH), .SELW(SELW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [3:0] s;
    logic       v;
    logic [3:0] rdy;
    logic       expReady;
    logic [3:0] expValid;
    logic [7:0] expData;
  } vec_t;

  typedef struct {
    int         ch;
    logic [7:0] d;
  } sb_t;

  sb_t  sbq[$];
  vec_t tbl[11];
  int   total = 0;
  int   bad   = 0;
  int   mDrop = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, check in_ready before the edge, then the scoreboard after it.
  task automatic applyStimulus(input logic [7:0] d, input logic [3:0] s, input logic v,
                               input logic [3:0] rdy, input logic expReady);
    sb_t e;
    in_data   = d;
    in_sel    = s;
    in_valid  = v;
    out_ready = rdy;
    #1;
    checkOutput("in_ready", 32'(in_ready), 32'(expReady));
    if (v && expReady && int'(s) < NCH) sbq.push_back('{int'(s), d});
    if (v && int'(s) >= NCH && mDrop < 255) mDrop++;
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checkOutput("sb_data", 32'(out_data[e.ch*DW +: DW]), 32'(e.d));
      checkOutput("sb_valid", 32'(out_valid[e.ch]), 32'd1);
    end
    checkOutput("drop_cnt", 32'(drop_cnt), mDrop);
  endtask

  initial begin
    tbl[0]  = '{8'hA0, 4'd0, 1'b1, 4'b0000, 1'b1, 4'b0001, 8'hA0};
    tbl[1]  = '{8'hA1, 4'd1, 1'b1, 4'b0000, 1'b1, 4'b0011, 8'hA1};
    tbl[2]  = '{8'hA2, 4'd2, 1'b1, 4'b0000, 1'b1, 4'b0111, 8'hA2};
    tbl[3]  = '{8'hA3, 4'd3, 1'b1, 4'b0000, 1'b1, 4'b1111, 8'hA3};
    tbl[4]  = '{8'h55, 4'd2, 1'b1, 4'b0000, 1'b0, 4'b1111, 8'hA2};
    tbl[5]  = '{8'h55, 4'd2, 1'b1, 4'b0100, 1'b1, 4'b1111, 8'h55};
    tbl[6]  = '{8'h00, 4'd0, 1'b0, 4'b0001, 1'b1, 4'b1110, 8'hA0};
    tbl[7]  = '{8'h66, 4'd0, 1'b1, 4'b0000, 1'b1, 4'b1111, 8'h66};
    tbl[8]  = '{8'h77, 4'd3, 1'b1, 4'b1000, 1'b1, 4'b1111, 8'h77};
    tbl[9]  = '{8'h88, 4'd7, 1'b1, 4'b0110, 1'b1, 4'b1001, 8'h00};
    tbl[10] = '{8'h99, 4'd1, 1'b1, 4'b0000, 1'b1, 4'b1011, 8'h99};

    rst_n     = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    out_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data", out_data, 32'd0);
    checkOutput("rst_drop", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
    for (int sel = 0; sel < 16; sel++) begin
      in_sel = 4'(sel);
      #1;
      checkOutput("idle_ready", 32'(in_ready), 32'd1);
    end
    @(posedge clk);
    #1;
    checkOutput("idle_valid", 32'(out_valid), 32'd0);

    $display("[TB] vector table");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].d, tbl[i].s, tbl[i].v, tbl[i].rdy, tbl[i].expReady);
      checkOutput("tbl_valid", 32'(out_valid), 32'(tbl[i].expValid));
      if (int'(tbl[i].s) < NCH)
        checkOutput("tbl_slice", 32'(out_data[int'(tbl[i].s)*DW +: DW]), 32'(tbl[i].expData));
    end

    $display("[TB] streaming on channel 1");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(8'(8'h10 + k), 4'd1, 1'b1, 4'b0010, 1'b1);
      checkOutput("stream_valid", 32'(out_valid), 32'b1011);
    end
    applyStimulus(8'h00, 4'd1, 1'b0, 4'b0010, 1'b1);
    checkOutput("stream_drain", 32'(out_valid), 32'b1001);
    checkOutput("stream_hold", 32'(out_data[1*DW +: DW]), 32'h17);

    $display("[TB] drop saturation");
    for (int k = 0; k < 300; k++) begin
      applyStimulus(8'hEE, 4'd5, 1'b1, 4'b0000, 1'b1);
    end
    checkOutput("drop_valid", 32'(out_valid), 32'b1001);
    checkOutput("drop_sat", 32'(drop_cnt), 32'd255);

    $display("[TB] asynchronous reset mid-operation");
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_drop", 32'(drop_cnt), 32'd0);
    checkOutput("arst_data", out_data, 32'd0);
    mDrop = 0;
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(8'hA5, 4'd3, 1'b1, 4'b0000, 1'b1);
    checkOutput("post_rst_valid", 32'(out_valid), 32'b1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
